// File: rtl/dll_pkg.sv
// Shared Data Link Layer types: sequence width, DLLP type codes, Ack/Nak request states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dll_pkg;

  localparam int SEQ_W = 12;

  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_ACK = 2'd1,
    REQ_NAK = 2'd2
  } acknak_state_t;

  // Forward distance from b to a in sequence space; modulo 2**SEQ_W falls out of the width.
  function automatic logic [SEQ_W-1:0] seq_diff(input logic [SEQ_W-1:0] a,
                                                input logic [SEQ_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/dll_ack_timer.sv
// Ack latency timer: counts while run is high, saturates at ACK_LATENCY-1 and flags expiry.
// Latency: expire is combinational from the count; the count reaches ACK_LATENCY-1 after that many run cycles.
// Backpressure: none; the count holds at the limit until clear.
module dll_ack_timer #(
  parameter int ACK_LATENCY = 256,
  parameter int TMR_W       = 9
) (
  input  logic clk,
  input  logic preset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(ACK_LATENCY - 1);

  logic [TMR_W-1:0] count;

  // Counter: clear wins, otherwise advance while running until the limit, then hold.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expire = run && (count == LIMIT);

endmodule

// File: rtl/dll_acknak_scheduler.sv
// Receive-side Ack/Nak scheduler: classifies each finished TLP, owns NEXT_RCV_SEQ/NAK_SCHEDULED, requests Ack/Nak DLLPs.
// Latency: accept/drop one cycle after tlp_done_i; DLLP request one cycle after the scheduling edge.
// Backpressure: dllp_req_o holds until dllp_gnt_i; events arriving meanwhile are merged (Nak overrides Ack).
module dll_acknak_scheduler #(
  parameter int SEQ_W       = 12,
  parameter int ACK_LATENCY = 256,
  parameter int TMR_W       = 9
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             DL_up,
  input  logic             tlp_done_i,
  input  logic [SEQ_W-1:0] tlp_seq_i,
  input  logic             tlp_lcrc_ok_i,
  output logic             tlp_accept_o,
  output logic             tlp_drop_o,
  output logic             dllp_req_o,
  output logic             dllp_is_nak_o,
  output logic [SEQ_W-1:0] dllp_seq_o,
  input  logic             dllp_gnt_i,
  output logic [SEQ_W-1:0] next_rcv_seq_o,
  output logic             nak_scheduled_o
);

  import dll_pkg::acknak_state_t;
  import dll_pkg::IDLE;
  import dll_pkg::REQ_ACK;
  import dll_pkg::REQ_NAK;
  import dll_pkg::seq_diff;

  // Duplicates are anything up to half the sequence space behind NRS.
  localparam logic [SEQ_W-1:0] HALF = SEQ_W'(1) << (SEQ_W - 1);

  acknak_state_t    state, state_nx;
  logic [SEQ_W-1:0] nrs;
  logic             nak_sched;
  logic             ack_pending;
  logic             nak_evt_q;
  logic             dup_q;

  logic [SEQ_W-1:0] d;
  logic             done_v, is_acc, is_dup, is_bad, nak_evt;
  logic             granted, ack_granted, expire, expire_evt;
  logic             tmr_run, tmr_clear;

  // Classify the TLP presented this cycle and qualify the grant.
  always_comb begin
    d           = seq_diff(nrs, tlp_seq_i);
    done_v      = DL_up && tlp_done_i;
    is_acc      = done_v && tlp_lcrc_ok_i && (d == '0);
    is_dup      = done_v && tlp_lcrc_ok_i && (d != '0) && (d <= HALF);
    is_bad      = done_v && !is_acc && !is_dup;
    nak_evt     = is_bad && !nak_sched;
    granted     = dllp_gnt_i && (state != IDLE);
    ack_granted = granted && (state == REQ_ACK);
    // Expiry in the grant cycle belongs to the Ack being granted, not a new one.
    expire_evt  = expire && !granted;
  end

  // Receive bookkeeping: decision pulses, NRS, NAK_SCHEDULED, ack_pending, scheduling events.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      tlp_accept_o <= 1'b0;
      tlp_drop_o   <= 1'b0;
      nrs          <= '0;
      nak_sched    <= 1'b0;
      ack_pending  <= 1'b0;
      nak_evt_q    <= 1'b0;
      dup_q        <= 1'b0;
    end else if (!DL_up) begin
      tlp_accept_o <= 1'b0;
      tlp_drop_o   <= 1'b0;
      nrs          <= '0;
      nak_sched    <= 1'b0;
      ack_pending  <= 1'b0;
      nak_evt_q    <= 1'b0;
      dup_q        <= 1'b0;
    end else begin
      tlp_accept_o <= is_acc;
      tlp_drop_o   <= is_dup || is_bad;
      nak_evt_q    <= nak_evt;
      dup_q        <= is_dup;
      if (is_acc) begin
        nrs       <= nrs + SEQ_W'(1);
        nak_sched <= 1'b0;
      end else if (nak_evt) begin
        nak_sched <= 1'b1;
      end
      // A fresh acceptance outranks a concurrent Ack grant: that TLP is still unacknowledged.
      if (is_acc) begin
        ack_pending <= 1'b1;
      end else if (ack_granted) begin
        ack_pending <= 1'b0;
      end
    end
  end

  assign tmr_run   = ack_pending && !nak_sched;
  assign tmr_clear = !DL_up || !ack_pending || granted;

  dll_ack_timer #(
    .ACK_LATENCY (ACK_LATENCY),
    .TMR_W       (TMR_W)
  ) u_ack_timer (
    .clk    (clk),
    .preset (preset),
    .run    (tmr_run),
    .clear  (tmr_clear),
    .expire (expire)
  );

  // Request state register.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request next state and outputs: grant retires the request, Nak overrides, Ack only from idle.
  always_comb begin
    state_nx      = state;
    dllp_req_o    = (state != IDLE);
    dllp_is_nak_o = (state == REQ_NAK);
    if (!DL_up) begin
      state_nx = IDLE;
    end else begin
      if (granted) begin
        state_nx = IDLE;
      end
      if (nak_evt_q) begin
        state_nx = REQ_NAK;
      end else if ((dup_q || expire_evt) && (state_nx == IDLE)) begin
        state_nx = REQ_ACK;
      end
    end
  end

  assign dllp_seq_o      = nrs - SEQ_W'(1);
  assign next_rcv_seq_o  = nrs;
  assign nak_scheduled_o = nak_sched;

endmodule

// File: tb/tb_dll_acknak_scheduler.sv
// Scoreboard bench for dll_acknak_scheduler: directed TLP sequences, expected decisions/requests queued at issue.
// Latency: checks accept/drop at +1 cycle, request at +1 cycle or ACK_LATENCY cycles.
// Backpressure: grant is driven explicitly by the stimulus.
module tb_dll_acknak_scheduler;

  localparam int SEQ_W = 12;
  localparam int LAT   = 32;
  localparam int TMR_W = 6;

  logic             clk = 1'b0;
  logic             preset = 1'b1;
  logic             DL_up = 1'b1;
  logic             tlp_done_i = 1'b0;
  logic [SEQ_W-1:0] tlp_seq_i = '0;
  logic             tlp_lcrc_ok_i = 1'b0;
  logic             tlp_accept_o, tlp_drop_o, dllp_req_o, dllp_is_nak_o, nak_scheduled_o;
  logic [SEQ_W-1:0] dllp_seq_o, next_rcv_seq_o;
  logic             dllp_gnt_i = 1'b0;

  dll_acknak_scheduler #(
    .SEQ_W       (SEQ_W),
    .ACK_LATENCY (LAT),
    .TMR_W       (TMR_W)
  ) dut (
    .clk             (clk),
    .preset          (preset),
    .DL_up           (DL_up),
    .tlp_done_i      (tlp_done_i),
    .tlp_seq_i       (tlp_seq_i),
    .tlp_lcrc_ok_i   (tlp_lcrc_ok_i),
    .tlp_accept_o    (tlp_accept_o),
    .tlp_drop_o      (tlp_drop_o),
    .dllp_req_o      (dllp_req_o),
    .dllp_is_nak_o   (dllp_is_nak_o),
    .dllp_seq_o      (dllp_seq_o),
    .dllp_gnt_i      (dllp_gnt_i),
    .next_rcv_seq_o  (next_rcv_seq_o),
    .nak_scheduled_o (nak_scheduled_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { bit acc; int nrs; } dec_t;
  typedef struct { bit nak; int seq; } req_t;

  dec_t dec_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_req_en = 1'b1;
  bit   req_prev = 1'b0;
  bit   nak_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a decision or a new/changed request.
  always @(negedge clk) begin
    if (!preset) begin
      if (tlp_accept_o || tlp_drop_o) begin
        if (dec_q.size() == 0) begin
          chk("unexpected_decision", 1, 0);
        end else begin
          dec_t e;
          e = dec_q.pop_front();
          chk("dec_accept", int'(tlp_accept_o), int'(e.acc));
          chk("dec_drop", int'(tlp_drop_o), int'(!e.acc));
          chk("dec_nrs", int'(next_rcv_seq_o), e.nrs);
        end
      end
      if (mon_req_en && dllp_req_o && (!req_prev || (dllp_is_nak_o != nak_prev))) begin
        if (req_q.size() == 0) begin
          chk("unexpected_request", 1, 0);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_is_nak", int'(dllp_is_nak_o), int'(r.nak));
          chk("req_seq", int'(dllp_seq_o), r.seq);
        end
      end
      req_prev = dllp_req_o;
      nak_prev = dllp_is_nak_o;
    end
  end

  task automatic exp_dec(input bit acc, input int nrs);
    dec_t e;
    e.acc = acc;
    e.nrs = nrs;
    dec_q.push_back(e);
  endtask

  task automatic exp_req(input bit nak, input int seq);
    req_t r;
    r.nak = nak;
    r.seq = seq;
    req_q.push_back(r);
  endtask

  // One TLP: done for one cycle; returns just after the decision edge.
  task automatic send(input int seq, input bit ok);
    @(posedge clk); #1;
    tlp_done_i = 1'b1; tlp_seq_i = SEQ_W'(seq); tlp_lcrc_ok_i = ok;
    @(posedge clk); #1;
    tlp_done_i = 1'b0;
  endtask

  task automatic grant();
    @(posedge clk); #1 dllp_gnt_i = 1'b1;
    @(posedge clk); #1 dllp_gnt_i = 1'b0;
  endtask

  task automatic link_reset();
    @(posedge clk); #1 DL_up = 1'b0;
    @(posedge clk); #1 DL_up = 1'b1;
  endtask

  // Bounded wait for dllp_req_o; returns the cycle count at which it was seen, -1 on timeout.
  task automatic wait_req(input string name, input int budget, output int at);
    int n;
    n = 0;
    at = -1;
    while (!dllp_req_o && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (dllp_req_o) at = cyc;
    else chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int t0, at;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", int'(dllp_req_o), 0);
    chk("rst_accept", int'(tlp_accept_o | tlp_drop_o), 0);
    chk("rst_nrs", int'(next_rcv_seq_o), 0);
    chk("rst_nak", int'(nak_scheduled_o), 0);
    chk("rst_dllp_seq", int'(dllp_seq_o), 4095);
    @(posedge clk); #1 preset = 1'b0;

    // Ten in-order TLPs, Ack after the latency window
    exp_req(1'b0, 9);
    for (int i = 0; i < 10; i++) begin
      exp_dec(1'b1, i + 1);
      send(i, 1'b1);
      if (i == 0) t0 = cyc;
    end
    chk("nrs_after_ten", int'(next_rcv_seq_o), 10);
    wait_req("ack_timer", LAT + 4, at);
    chk("ack_latency", at - t0, LAT);
    grant();
    chk("req_cleared", int'(dllp_req_o), 0);
    repeat (LAT + 4) @(negedge clk);
    chk("no_reack_after_grant", int'(dllp_req_o), 0);

    // Ahead-of-sequence Nak, merged bad LCRC, in-order recovery
    link_reset();
    for (int i = 0; i < 3; i++) begin
      exp_dec(1'b1, i + 1);
      send(i, 1'b1);
    end
    exp_dec(1'b0, 3);
    exp_req(1'b1, 2);
    send(5, 1'b1);
    t0 = cyc;
    chk("nak_flag_set", int'(nak_scheduled_o), 1);
    wait_req("nak_req", 4, at);
    chk("nak_latency", at - t0, 1);
    exp_dec(1'b0, 3);
    send(7, 1'b0);
    repeat (3) @(negedge clk);
    grant();
    chk("nak_granted_req", int'(dllp_req_o), 0);
    chk("nak_flag_kept", int'(nak_scheduled_o), 1);
    exp_dec(1'b0, 3);
    send(3, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_second_nak", int'(dllp_req_o), 0);
    exp_dec(1'b1, 4);
    send(3, 1'b1);
    chk("nak_flag_cleared", int'(nak_scheduled_o), 0);

    // Duplicate: immediate Ack
    exp_dec(1'b0, 4);
    exp_req(1'b0, 3);
    send(1, 1'b1);
    t0 = cyc;
    wait_req("dup_ack", 4, at);
    chk("dup_latency", at - t0, 1);
    grant();

    // Ack pending, Nak overrides before grant
    exp_dec(1'b1, 5);
    exp_req(1'b0, 4);
    send(4, 1'b1);
    t0 = cyc;
    wait_req("ack_timer2", LAT + 4, at);
    chk("ack_latency2", at - t0, LAT);
    exp_dec(1'b0, 5);
    exp_req(1'b1, 4);
    send(9, 1'b0);
    repeat (2) @(negedge clk);
    chk("upgrade_to_nak", int'(dllp_is_nak_o), 1);
    chk("upgrade_req_held", int'(dllp_req_o), 1);
    grant();
    exp_dec(1'b1, 6);
    exp_req(1'b0, 5);
    send(5, 1'b1);
    t0 = cyc;
    wait_req("ack_after_nak", LAT + 4, at);
    chk("ack_latency3", at - t0, LAT);

    // Grant and acceptance in the same cycle: timer restarts
    exp_dec(1'b1, 7);
    @(posedge clk); #1;
    tlp_done_i = 1'b1; tlp_seq_i = SEQ_W'(6); tlp_lcrc_ok_i = 1'b1; dllp_gnt_i = 1'b1;
    @(posedge clk); #1;
    tlp_done_i = 1'b0; dllp_gnt_i = 1'b0;
    t0 = cyc;
    chk("gnt_acc_req_low", int'(dllp_req_o), 0);
    exp_req(1'b0, 6);
    wait_req("ack_restart", LAT + 4, at);
    chk("ack_restart_latency", at - t0, LAT);

    // Acceptance while Ack pending refreshes dllp_seq_o; then link drop mid-request
    exp_dec(1'b1, 8);
    send(7, 1'b1);
    chk("seq_refresh", int'(dllp_seq_o), 7);
    @(posedge clk); #1;
    DL_up = 1'b0; tlp_done_i = 1'b1; tlp_seq_i = SEQ_W'(8); tlp_lcrc_ok_i = 1'b1;
    @(posedge clk); #1 tlp_done_i = 1'b0;
    chk("down_req", int'(dllp_req_o), 0);
    chk("down_nrs", int'(next_rcv_seq_o), 0);
    chk("down_nak", int'(nak_scheduled_o), 0);
    chk("down_dllp_seq", int'(dllp_seq_o), 4095);
    @(posedge clk); #1 DL_up = 1'b1;
    chk("down_ignored", int'(tlp_accept_o | tlp_drop_o), 0);

    // Sequence wrap: walk NRS up to 4095 with grants absorbing timer Acks
    mon_req_en = 1'b0;
    dllp_gnt_i = 1'b1;
    for (int i = 0; i < 4095; i++) begin
      exp_dec(1'b1, (i + 1) % 4096);
      @(posedge clk); #1;
      tlp_done_i = 1'b1; tlp_seq_i = SEQ_W'(i); tlp_lcrc_ok_i = 1'b1;
    end
    @(posedge clk); #1;
    tlp_done_i = 1'b0; dllp_gnt_i = 1'b0;
    wait_req("wrap_drain", LAT + 4, at);
    grant();
    repeat (2) @(negedge clk);
    mon_req_en = 1'b1;
    chk("wrap_nrs_4095", int'(next_rcv_seq_o), 4095);
    chk("wrap_dllp_seq_4094", int'(dllp_seq_o), 4094);
    exp_dec(1'b1, 0);
    send(4095, 1'b1);
    chk("wrap_nrs_0", int'(next_rcv_seq_o), 0);
    chk("wrap_dllp_seq_4095", int'(dllp_seq_o), 4095);
    exp_dec(1'b0, 0);
    exp_req(1'b0, 4095);
    send(2048, 1'b1);
    wait_req("wrap_dup", 4, at);
    grant();
    exp_dec(1'b0, 0);
    exp_req(1'b1, 4095);
    send(2047, 1'b1);
    wait_req("wrap_nak", 4, at);
    chk("wrap_nak_flag", int'(nak_scheduled_o), 1);
    grant();
    repeat (4) @(negedge clk);

    chk("dec_queue_drained", dec_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/dll_acknak_scheduler.md
# dll_acknak_scheduler

Receive-side Ack/Nak controller for the Data Link Layer. It sits between the DLL TLP decoder and the DLLP transmit path. For every TLP the decoder finishes, it judges the sequence number and LCRC result, then tells the decoder to forward or drop the TLP. It also owns NEXT_RCV_SEQ, the NAK_SCHEDULED flag and the Ack latency timer, and schedules Ack/Nak DLLP requests to the transmitter.

## Interface
Parameters:
- SEQ_W, 12, sequence-number width (modulo 4096).
- ACK_LATENCY, 256, cycles from the first unacknowledged accepted TLP to the Ack request; minimum 1.
- TMR_W, 9, timer width; must hold ACK_LATENCY.

Ports:
- clk  in  1  single clock.
- preset  in  1  asynchronous, active-high reset.
- DL_up  in  1  link up from DLCMSM; low acts as a synchronous clear of all state.
- tlp_done_i  in  1  one-cycle pulse: decoder finished a TLP.
- tlp_seq_i  in  SEQ_W  sequence number of that TLP, valid with tlp_done_i.
- tlp_lcrc_ok_i  in  1  LCRC check passed, valid with tlp_done_i.
- tlp_accept_o  out  1  pulse: forward the TLP to the Transaction Layer.
- tlp_drop_o  out  1  pulse: discard the TLP.
- dllp_req_o  out  1  Ack/Nak DLLP request; held until granted.
- dllp_is_nak_o  out  1  1 = Nak, 0 = Ack; valid while dllp_req_o is high.
- dllp_seq_o  out  SEQ_W  AckNak_Seq_Num, always NEXT_RCV_SEQ−1 mod 4096.
- dllp_gnt_i  in  1  transmitter took the DLLP this cycle.
- next_rcv_seq_o  out  SEQ_W  current NEXT_RCV_SEQ.
- nak_scheduled_o  out  1  NAK_SCHEDULED flag.

## Operation
- Reset, or DL_up=0: NRS=0, NAK_SCHEDULED=0, ack_pending=0, timer=0, all outputs 0. dllp_seq_o therefore reads 4095. tlp_done_i is ignored while DL_up=0.
- Classification uses d = (NRS − tlp_seq_i) mod 4096:
  - LCRC bad: drop. If NAK_SCHEDULED=0, set it and schedule a Nak.
  - LCRC good and d==0: accept. NRS++ (wraps 4095→0). Clear NAK_SCHEDULED. Set ack_pending.
  - LCRC good and 1≤d≤2048 (duplicate): drop. Schedule an immediate Ack.
  - LCRC good otherwise (ahead of NRS): drop. If NAK_SCHEDULED=0, set it and schedule a Nak.
- Timer:
  - Runs while ack_pending=1 and NAK_SCHEDULED=0. It starts at 0 on the cycle ack_pending rises.
  - Accepting further TLPs does not restart it.
  - On reaching ACK_LATENCY−1 it schedules an Ack and holds.
- Request state machine, states IDLE / REQ_ACK / REQ_NAK:
  - IDLE→REQ_NAK on a Nak event.
  - IDLE→REQ_ACK on a duplicate or on timer expiry.
  - REQ_ACK→REQ_NAK if a Nak event arrives before grant. Nak has priority.
  - A Nak or Ack request already in REQ_NAK/REQ_ACK absorbs further same-type events.
  - On dllp_gnt_i: return to IDLE and clear the timer. A granted Ack also clears ack_pending.
- A granted Nak leaves NAK_SCHEDULED set. Only an in-order good TLP clears it.

## Timing
- Registered decision: tlp_accept_o or tlp_drop_o pulses exactly 1 cycle after tlp_done_i. NRS and NAK_SCHEDULED update on that same edge.
- dllp_req_o rises 1 cycle after the scheduling event: the decision edge or the timer-expiry edge.
- dllp_req_o, dllp_is_nak_o and dllp_seq_o must stay stable from request until grant. The one exception is a NRS increment from a newly accepted TLP, which updates dllp_seq_o before grant. This keeps the Ack current.
- Grant and acceptance in the same cycle: the grant takes the old dllp_seq_o. ack_pending stays set because a new TLP is unacknowledged, and the timer restarts at 0.
- Grant and Nak event in the same cycle: the grant completes, and REQ_NAK is entered the next cycle.
- dllp_gnt_i while dllp_req_o=0 is ignored.
- DL_up falling mid-request: dllp_req_o drops the next cycle and the request is not completed.

## Structure
- Shared package dll_pkg:
  - SEQ_W
  - DLLP type constants DLLP_ACK=8'h00 and DLLP_NAK=8'h10
  - enum acknak_state_t {IDLE, REQ_ACK, REQ_NAK}
  - function seq_diff(a,b), returning (a−b) mod 4096
- One sub-module, dll_ack_timer: holds the counter, run/clear inputs and an expire output. All other logic is in the top.

## Test plan
- Ten good TLPs, seq 0..9, no grant → ten accept pulses, then NRS=10. Ack request rises ACK_LATENCY cycles after the first accept, with dllp_seq_o=9. Grant → ack_pending=0.
- Good TLP seq 5 when NRS=3 → drop, Nak request with seq 2, NAK_SCHEDULED=1. A second bad-LCRC TLP → no second Nak request. Good seq 3 → accept, NAK_SCHEDULED=0.
- Good TLP seq 1 when NRS=4 (duplicate) → drop, and an immediate Ack request with seq 3 on the next cycle.
- Wrap: NRS=4095, good seq 4095 → accept, NRS=0, dllp_seq_o=4095. Seq 2048 arriving at NRS=0 → duplicate (d=2048). Seq 2047 → Nak (d=2049).
- Ack pending, Nak event before grant → dllp_is_nak_o switches to 1. Grant and accept in the same cycle → timer restarts and ack_pending=1.
- DL_up drops mid-request → dllp_req_o=0 the next cycle, NRS=0, and all flags clear.
